tone_shaper: RTL and testbench

TONE_SHAPER -- requirements
Module: tone_shaper

---
 rtl/tone_pkg.sv | 17 +
 rtl/half_period_cnt.sv | 39 +++
 rtl/tone_shaper.sv | 116 +++++++++++
 tb/tb_tone_shaper.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants and state encoding for the tone shaper.
// Holds the divider width, the rest/terminal divider value and the FSM state type.
// Imported by tone_shaper and half_period_cnt.
package tone_pkg;

  localparam int TN_W = 11;
  localparam logic [TN_W-1:0] TN_REST = '1;  // preload meaning "no tone"
  localparam logic [TN_W-1:0] TN_MAX  = '1;  // half-period counter terminal value

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2,
    ST_REST = 2'd3
  } state_e;

endpackage

// File: rtl/half_period_cnt.sv
// Loadable up-counter with a terminal flag; times one half-period of the tone.
// Ports: clk/rst, clr (to 0), load (with load_val), inc (count up), term (count at all-ones).
// Priority rst > clr > load > inc; the count never wraps because inc is ignored at terminal.
module half_period_cnt import tone_pkg::*; #(
  parameter int W = tone_pkg::TN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         term
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term = (cnt_q == CNT_MAX);

endmodule

// File: rtl/tone_shaper.sv
// Beat-driven square-wave tone generator: silent gap after every beat, then a
// 50%-duty tone with half-period (2^TN_W - tn_q) cycles, or silence for a rest.
// Ports: clk, rst (sync, high), tn/beat/en in; spk, active, state_o out (all registered).
module tone_shaper import tone_pkg::*; #(
  parameter int TN_W       = tone_pkg::TN_W,
  parameter int GAP_CYCLES = 8000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TN_W-1:0] tn,
  input  logic            beat,
  input  logic            en,
  output logic            spk,
  output logic            active,
  output logic [1:0]      state_o
);

  localparam int              GAP_W    = 16;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TN_W-1:0]  TN_ALL1  = '1;

  state_e            state_q, state_d;
  logic              spk_q, spk_d;
  logic              active_q, active_d;
  logic [TN_W-1:0]   tn_q, tn_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              hp_clr, hp_load, hp_inc, hp_term;

  half_period_cnt #(.W(TN_W)) u_hp_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (hp_clr),
    .load     (hp_load),
    .load_val (tn_q),
    .inc      (hp_inc),
    .term     (hp_term)
  );

  always_comb begin
    state_d = state_q;
    spk_d   = spk_q;
    tn_d    = tn_q;
    gap_d   = gap_q;
    hp_clr  = 1'b0;
    hp_load = 1'b0;
    hp_inc  = 1'b0;

    // Mute wins over a simultaneous beat.
    if (!en) begin
      state_d = ST_IDLE;
      spk_d   = 1'b0;
      gap_d   = '0;
      hp_clr  = 1'b1;
    end else if (beat) begin
      // A beat in any state restarts articulation; spk drops at once so no
      // partial half-period of the old note survives.
      state_d = ST_GAP;
      gap_d   = GAP_LOAD;
      spk_d   = 1'b0;
      tn_d    = tn;
      hp_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_GAP: begin
          spk_d = 1'b0;
          if (gap_q == '0) begin
            if (tn_q == TN_ALL1) begin
              state_d = ST_REST;
            end else begin
              state_d = ST_TONE;
              hp_load = 1'b1;
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        ST_TONE: begin
          // Reload and toggle in the same cycle the count hits terminal, so a
          // half-period spans tn_q..all-ones inclusive.
          if (hp_term) begin
            hp_load = 1'b1;
            spk_d   = ~spk_q;
          end else begin
            hp_inc = 1'b1;
          end
        end
        ST_REST: spk_d = 1'b0;
        default: ;  // IDLE waits for a beat
      endcase
    end

    active_d = (state_d == ST_TONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      spk_q    <= 1'b0;
      active_q <= 1'b0;
      tn_q     <= TN_ALL1;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      spk_q    <= spk_d;
      active_q <= active_d;
      tn_q     <= tn_d;
      gap_q    <= gap_d;
    end
  end

  assign spk     = spk_q;
  assign active  = active_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_tone_shaper.sv
// Self-checking bench for tone_shaper with GAP_CYCLES=4.
// Reference model tracks "cycles since last honoured beat" and derives the
// expected state and speaker level arithmetically.
module tb_tone_shaper;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] tn  = 11'd0;
  logic        beat = 1'b0;
  logic        en   = 1'b0;
  logic        spk;
  logic        active;
  logic [1:0]  state_o;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  bit m_play = 1'b0;
  int m_tn   = 2047;
  int m_t    = 0;

  tone_shaper #(.TN_W(11), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .tn      (tn),
    .beat    (beat),
    .en      (en),
    .spk     (spk),
    .active  (active),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs the DUT samples, then compare.
  task automatic step();
    int exp_st;
    int exp_spk;
    int k;
    @(posedge clk);
    if (rst) begin
      m_play = 1'b0;
      m_tn   = 2047;
    end else if (!en) begin
      m_play = 1'b0;
    end else if (beat) begin
      m_play = 1'b1;
      m_tn   = int'(tn);
      m_t    = 1;
    end else if (m_play) begin
      m_t++;
    end
    #1;
    exp_spk = 0;
    if (!m_play)            exp_st = 0;
    else if (m_t <= GAP)    exp_st = 1;
    else if (m_tn == 2047)  exp_st = 3;
    else begin
      exp_st  = 2;
      k       = m_t - GAP - 1;
      exp_spk = (k / (2048 - m_tn)) % 2;
    end
    check_val("state", 32'(state_o), 32'(exp_st));
    check_val("spk", 32'(spk), 32'(exp_spk));
    check_val("active", 32'(active), 32'(exp_st == 2));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_beat(input logic [10:0] v);
    tn   = v;
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    run(3);
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_spk", 32'(spk), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    run(2);

    // tn=1024: 4-cycle gap, tone from cycle 5, toggle every 1024 cycles
    pulse_beat(11'd1024);
    tn = 11'd5;  // changes between beats must be ignored
    check_val("t1_gap_c1", 32'(state_o), 32'd1);
    run(3);
    check_val("t1_gap_c4", 32'(state_o), 32'd1);
    check_val("t1_gap_spk", 32'(spk), 32'd0);
    step();
    check_val("t1_tone_c5", 32'(state_o), 32'd2);
    check_val("t1_active_c5", 32'(active), 32'd1);
    run(1023);
    check_val("t1_pre_rise", 32'(spk), 32'd0);
    step();
    check_val("t1_rise", 32'(spk), 32'd1);
    run(1024);
    check_val("t1_fall", 32'(spk), 32'd0);
    run(100);

    // tn=2046: period 4
    pulse_beat(11'd2046);
    run(GAP);
    check_val("t2_tone", 32'(state_o), 32'd2);
    run(40);

    // tn=2047: rest for 10000 cycles
    pulse_beat(11'd2047);
    run(GAP);
    check_val("t3_rest", 32'(state_o), 32'd3);
    run(10000);
    check_val("t3_rest_end", 32'(state_o), 32'd3);

    // mid-tone beat with spk high: immediate mute, gap, then half-period 512
    pulse_beat(11'd1024);
    run(GAP + 1500);
    check_val("t4_spk_hi", 32'(spk), 32'd1);
    pulse_beat(11'd1536);
    check_val("t4_mute", 32'(spk), 32'd0);
    check_val("t4_gap", 32'(state_o), 32'd1);
    run(GAP + 511);
    check_val("t4_pre_rise", 32'(spk), 32'd0);
    step();
    check_val("t4_rise", 32'(spk), 32'd1);
    run(600);

    // beat with en=0: mute wins; re-enable without beat stays idle
    en = 1'b0;
    pulse_beat(11'd1000);
    check_val("t5_idle", 32'(state_o), 32'd0);
    check_val("t5_spk", 32'(spk), 32'd0);
    en = 1'b1;
    run(20);
    check_val("t5_stay_idle", 32'(state_o), 32'd0);

    // one-cycle reset mid-tone
    pulse_beat(11'd2040);
    run(GAP + 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_rst_state", 32'(state_o), 32'd0);
    check_val("t6_rst_active", 32'(active), 32'd0);
    run(30);
    check_val("t6_no_out", 32'(state_o), 32'd0);

    // randomized mix of beats, notes, rests, mutes and resets
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       tn = 11'd2047;
        1:       tn = 11'($urandom_range(0, 2047));
        default: tn = 11'($urandom_range(2030, 2046));
      endcase
      beat = ($urandom_range(0, 99) == 0);
      if (!en) en = ($urandom_range(0, 9) == 0);
      else     en = ($urandom_range(0, 299) != 0);
      rst  = ($urandom_range(0, 999) == 0);
      step();
    end
    rst  = 1'b0;
    beat = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
